// File: rtl/tx_pkg.sv
// Shared Tx framing types and constants used by the framer and the Rx checker.
package tx_pkg;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        CRC
    } frm_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          HDR_LEN    = 3;
    localparam int          CRC_LEN    = 2;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16-CCITT step (poly 0x1021, MSB first, no reflection), purely combinational.
module crc16_ccitt_byte
    import tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/tblock_crc_framer.sv
// Wraps each shaper transport block as sync(2) + seq(1) + payload + CRC-16(2).
// Payload passes through with zero latency; header/CRC bytes are held under backpressure.
module tblock_crc_framer
    import tx_pkg::*;
#(
    parameter int          size_tblck = 480,
    parameter logic [15:0] sync_word  = 16'hA5C3,
    parameter logic [15:0] crc_init   = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ival,
    input  logic [7:0] idata,
    input  logic       ireq,
    output logic       oval,
    output logic [7:0] odata,
    output logic       oreq,
    output logic       osop,
    output logic       oeop
);

    localparam int                CNT_W    = $clog2(size_tblck);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(size_tblck - 1);
    localparam logic [1:0]        HDR_LAST = 2'(HDR_LEN - 1);
    localparam logic              CRC_LAST = 1'(CRC_LEN - 1);

    frm_state_t        state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic              crc_idx_q, crc_idx_d;
    logic [7:0]        seq_q, seq_d;
    logic [15:0]       crc_q, crc_d;
    logic [CNT_W-1:0]  cnt_pay_q, cnt_pay_d;
    logic [15:0]       crc_upd;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_q),
        .data    (idata),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HDR;
            hdr_idx_q <= 2'd0;
            crc_idx_q <= 1'b0;
            seq_q     <= 8'd0;
            crc_q     <= crc_init;
            cnt_pay_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            crc_idx_q <= crc_idx_d;
            seq_q     <= seq_d;
            crc_q     <= crc_d;
            cnt_pay_q <= cnt_pay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        crc_idx_d = crc_idx_q;
        seq_d     = seq_q;
        crc_d     = crc_q;
        cnt_pay_d = cnt_pay_q;
        oval      = 1'b0;
        odata     = 8'h00;
        oreq      = 1'b0;
        osop      = 1'b0;
        oeop      = 1'b0;

        // Outputs are forced low during reset regardless of registered state.
        if (!rst) begin
            unique case (state_q)
                HDR: begin
                    oval = 1'b1;
                    osop = (hdr_idx_q == 2'd0);
                    case (hdr_idx_q)
                        2'd0:    odata = sync_word[15:8];
                        2'd1:    odata = sync_word[7:0];
                        default: odata = seq_q;
                    endcase
                    if (ireq) begin
                        if (hdr_idx_q == HDR_LAST) begin
                            state_d   = PAY;
                            cnt_pay_d = '0;
                            crc_d     = crc_init;
                        end else begin
                            hdr_idx_d = hdr_idx_q + 2'd1;
                        end
                    end
                end
                PAY: begin
                    oreq  = ireq;
                    oval  = ival;
                    odata = idata;
                    if (ireq && ival) begin
                        crc_d     = crc_upd;
                        cnt_pay_d = cnt_pay_q + 1'b1;
                        if (cnt_pay_q == CNT_LAST) begin
                            state_d   = CRC;
                            crc_idx_d = 1'b0;
                        end
                    end
                end
                CRC: begin
                    oval  = 1'b1;
                    odata = crc_idx_q ? crc_q[7:0] : crc_q[15:8];
                    oeop  = (crc_idx_q == CRC_LAST);
                    if (ireq) begin
                        if (crc_idx_q == CRC_LAST) begin
                            state_d   = HDR;
                            hdr_idx_d = 2'd0;
                            seq_d     = seq_q + 8'd1;
                        end else begin
                            crc_idx_d = 1'b1;
                        end
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_tblock_crc_framer.sv
module tb_tblock_crc_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: bit-serial LFSR form, feedback = crc[15] ^ data bit.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic build_exp(input int size, input logic [7:0] seq);
        logic [15:0] c;
        c = 16'hFFFF;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        exp_q.push_back(seq);
        for (int i = 0; i < size; i++) begin
            exp_q.push_back(pay_q[i]);
            c = crc_ref(c, pay_q[i]);
        end
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic cmp_stream(input string tag);
        logic [7:0] g;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
        end
    endtask

    // DUT A: 9-byte blocks
    logic       a_rst, a_ival, a_ireq, a_oval, a_oreq, a_osop, a_oeop;
    logic [7:0] a_idata, a_odata;

    tblock_crc_framer #(.size_tblck(9)) u_a (
        .clk(clk), .rst(a_rst), .ival(a_ival), .idata(a_idata), .ireq(a_ireq),
        .oval(a_oval), .odata(a_odata), .oreq(a_oreq), .osop(a_osop), .oeop(a_oeop)
    );

    // DUT B: 4-byte blocks for sequence wrap
    logic       b_rst, b_ival, b_ireq, b_oval, b_oreq, b_osop, b_oeop;
    logic [7:0] b_idata, b_odata;

    tblock_crc_framer #(.size_tblck(4)) u_b (
        .clk(clk), .rst(b_rst), .ival(b_ival), .idata(b_idata), .ireq(b_ireq),
        .oval(b_oval), .odata(b_odata), .oreq(b_oreq), .osop(b_osop), .oeop(b_oeop)
    );

    // DUT C: default parameters
    logic       c_rst, c_ival, c_ireq, c_oval, c_oreq, c_osop, c_oeop;
    logic [7:0] c_idata, c_odata;

    tblock_crc_framer u_c (
        .clk(clk), .rst(c_rst), .ival(c_ival), .idata(c_idata), .ireq(c_ireq),
        .oval(c_oval), .odata(c_odata), .oreq(c_oreq), .osop(c_osop), .oeop(c_oeop)
    );

    // Runs one full frame on DUT A with random ireq and an optional ival gap.
    task automatic run_a(input int rq_pct, input int gap_at, input int gap_len);
        int pi, gap, guard, nsop, neop;
        bit done, held, in_gap;
        logic [7:0] prev;
        pi = 0; gap = 0; guard = 0; nsop = 0; neop = 0;
        done = 1'b0; held = 1'b0; prev = 8'h00;
        got_q.delete();
        while (!done && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
            a_ireq  = ($urandom_range(99) < rq_pct);
            in_gap  = (pi == gap_at) && (gap < gap_len);
            if (in_gap) gap++;
            a_ival  = (pi < 9) && !in_gap;
            a_idata = (pi < 9) ? pay_q[pi] : 8'h00;
            @(negedge clk);
            if (held) begin
                chk("hold_oval", 32'(a_oval), 32'd1);
                chk("hold_odata", {24'd0, a_odata}, {24'd0, prev});
            end
            chk("oreq_gated", 32'(a_oreq & ~a_ireq), 32'd0);
            if (in_gap) begin
                chk("gap_oreq", 32'(a_oreq), 32'(a_ireq));
                chk("gap_oval", 32'(a_oval), 32'd0);
            end
            held = a_oval && !a_ireq;
            prev = a_odata;
            if (a_oval && a_ireq) begin
                got_q.push_back(a_odata);
                if (a_osop) begin
                    nsop++;
                    chk("sop_pos", 32'(got_q.size()), 32'd1);
                end
                if (a_oeop) begin
                    neop++;
                    done = 1'b1;
                end
            end
            if (a_oreq && a_ival) pi++;
        end
        chk("a_timeout", 32'(done), 32'd1);
        chk("a_nsop", 32'(nsop), 32'd1);
        chk("a_neop", 32'(neop), 32'd1);
    endtask

    logic [7:0] vec0 [14];

    initial begin
        int n, pi, guard;
        a_rst = 1'b1; a_ival = 1'b1; a_ireq = 1'b1; a_idata = 8'h5A;
        b_rst = 1'b1; b_ival = 1'b0; b_ireq = 1'b0; b_idata = 8'h00;
        c_rst = 1'b1; c_ival = 1'b0; c_ireq = 1'b0; c_idata = 8'h00;
        vec0 = '{8'hA5, 8'hC3, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};

        // Reset: outputs forced low even with ival/ireq high
        repeat (3) begin
            @(negedge clk);
            chk("rst_oval", 32'(a_oval), 32'd0);
            chk("rst_oreq", 32'(a_oreq), 32'd0);
            chk("rst_odata", {24'd0, a_odata}, 32'd0);
            chk("rst_sop_eop", 32'({a_osop, a_oeop}), 32'd0);
        end
        @(posedge clk);
        #1;
        a_rst = 1'b0; a_ireq = 1'b0; a_ival = 1'b0;
        @(negedge clk);
        chk("post_rst_oval", 32'(a_oval), 32'd1);
        chk("post_rst_osop", 32'(a_osop), 32'd1);
        chk("post_rst_odata", {24'd0, a_odata}, 32'hA5);

        // CRC check vector "123456789"
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
        run_a(100, -1, 0);
        chk("vec_len", 32'(got_q.size()), 32'd14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("vec_b%0d", i),
                {24'd0, (i < got_q.size()) ? got_q[i] : 8'hxx}, {24'd0, vec0[i]});

        // Backpressure: same payload, 50% ireq, seq 1
        run_a(50, -1, 0);
        build_exp(9, 8'd1);
        cmp_stream("bp");

        // Payload gap of 20 cycles mid-PAY, seq 2
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'((i * 29 + 7) & 255));
        run_a(70, 4, 20);
        build_exp(9, 8'd2);
        cmp_stream("gap");

        // Reset in the middle of the payload
        pi = 0; guard = 0;
        while (pi < 5 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
            a_ireq = 1'b1; a_ival = 1'b1; a_idata = pay_q[pi];
            @(negedge clk);
            if (a_oreq && a_ival) pi++;
        end
        chk("midrst_reach", 32'(pi), 32'd5);
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_oval", 32'(a_oval), 32'd0);
            chk("midrst_oreq", 32'(a_oreq), 32'd0);
            @(posedge clk);
            #1;
        end
        a_rst = 1'b0; a_ireq = 1'b0; a_ival = 1'b0;
        run_a(100, -1, 0);
        build_exp(9, 8'd0);
        cmp_stream("midrst");

        // Sequence wrap over 257 zero blocks of 4 bytes
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_ireq = 1'b1; b_ival = 1'b1; b_idata = 8'h00;
        n = 0; guard = 0;
        while (n < 257 * 9 + 3 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (b_oval && b_ireq) begin
                case (n % 9)
                    0: chk("wrap_sop", 32'(b_osop), 32'd1);
                    2: chk($sformatf("wrap_seq%0d", n / 9), {24'd0, b_odata}, 32'((n / 9) & 255));
                    7: chk("wrap_crc_hi", {24'd0, b_odata}, 32'h84);
                    8: begin
                        chk("wrap_crc_lo", {24'd0, b_odata}, 32'hC0);
                        chk("wrap_eop", 32'(b_oeop), 32'd1);
                    end
                    default: ;
                endcase
                n++;
            end
        end
        chk("wrap_count", 32'(n), 32'(257 * 9 + 3));
        @(posedge clk);
        #1;
        b_rst = 1'b1;

        // Shaper integration: 100 data bytes then zero padding to 480
        pay_q.delete();
        for (int i = 0; i < 480; i++) pay_q.push_back((i < 100) ? 8'((i * 37 + 11) & 255) : 8'h00);
        build_exp(480, 8'd0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h01);
        got_q.delete();
        c_rst = 1'b0; c_ireq = 1'b1; c_ival = 1'b1;
        pi = 0; guard = 0;
        while (got_q.size() < 488 && guard < 2000) begin
            c_idata = (pi < 480) ? pay_q[pi] : 8'h00;
            @(negedge clk);
            guard++;
            if (c_oval && c_ireq) begin
                if (got_q.size() == 484) chk("shp_eop", 32'(c_oeop), 32'd1);
                if (got_q.size() == 485) chk("shp_next_sop", 32'(c_osop), 32'd1);
                got_q.push_back(c_odata);
            end
            if (c_oreq && c_ival) pi++;
            @(posedge clk);
            #1;
        end
        cmp_stream("shp");
        c_rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
